// File: rtl/grey_updown_counter.sv
// grey_updown_counter: binary up/down counter with Gray-coded view,
// Gray-coded synchronous load and a one-cycle wrap pulse.
// Build option: define GREY_CNT_REG_OUT_EN to produce gray_out from a
// dedicated flop (CDC-safe); otherwise gray_out is decoded from bin_out.
module grey_updown_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_BIN = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_MIN = '0;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] load_bin;
  logic             wrap_q;
  logic             wrap_d;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray-to-binary decode of the load value: bit i is the XOR of gray bits i..MSB
  always_comb begin
    load_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load_bin[i] = ^(load_gray >> i);
    end
  end

  // Next count and wrap flag; load wins over a step and never flags a wrap
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_bin;
    end else if (en) begin
      if (up) begin
        count_d = count_q + CNT_ONE;
        wrap_d  = (count_q == CNT_MAX);
      end else begin
        count_d = count_q - CNT_ONE;
        wrap_d  = (count_q == CNT_MIN);
      end
    end
  end

  // Count and wrap registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_BIN;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bin_out = count_q;
  assign wrap    = wrap_q;

`ifdef GREY_CNT_REG_OUT_EN
  logic [WIDTH-1:0] gray_q;

  // Dedicated Gray flop loaded with Gray(next count), aligned with count_q
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q <= to_gray(RST_BIN);
    end else begin
      gray_q <= to_gray(count_d);
    end
  end

  assign gray_out = gray_q;
`else
  assign gray_out = to_gray(count_q);
`endif

endmodule

// File: tb/tb_grey_updown_counter.sv
// Self-checking bench for grey_updown_counter (WIDTH=4); a second instance
// with RST_VAL=5 shares the stimulus and is checked on reset cycles.
module tb_grey_updown_counter;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic         r;
    logic         e;
    logic         u;
    logic         l;
    logic [W-1:0] g;
  } stim_t;

  typedef struct packed {
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
    logic         step;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_gray = '0;
  logic [W-1:0] bin_out, gray_out, bin5, gray5;
  logic         wrap, wrap5;

  exp_t         sb[$];
  logic [W-1:0] m_bin = '0;
  logic         m_wrap = 1'b0;
  logic [W-1:0] prev_gray = '0;
  int           vectors = 0;
  int           errors = 0;

  grey_updown_counter #(.WIDTH(W), .RST_VAL(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .bin_out(bin_out), .gray_out(gray_out), .wrap(wrap)
  );

  grey_updown_counter #(.WIDTH(W), .RST_VAL(5)) u_dut5 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .bin_out(bin5), .gray_out(gray5), .wrap(wrap5)
  );

  always #5 clk = ~clk;

  // Apply one stimulus vector, advance the reference model, queue its result
  task automatic drive(input stim_t s);
    exp_t         x;
    logic [W-1:0] dec;
    rst = s.r; en = s.e; up = s.u; load = s.l; load_gray = s.g;
    if (s.r) begin
      m_bin  = '0;
      m_wrap = 1'b0;
    end else if (s.l) begin
      dec[W-1] = s.g[W-1];
      for (int i = W - 2; i >= 0; i--) dec[i] = s.g[i] ^ dec[i+1];
      m_bin  = dec;
      m_wrap = 1'b0;
    end else if (s.e) begin
      if (s.u) begin
        m_wrap = (m_bin == 4'd15);
        m_bin  = (m_bin == 4'd15) ? 4'd0 : m_bin + 4'd1;
      end else begin
        m_wrap = (m_bin == 4'd0);
        m_bin  = (m_bin == 4'd0) ? 4'd15 : m_bin - 4'd1;
      end
    end else begin
      m_wrap = 1'b0;
    end
    x.bin  = m_bin;
    x.gray = {m_bin[3], m_bin[3] ^ m_bin[2], m_bin[2] ^ m_bin[1], m_bin[1] ^ m_bin[0]};
    x.wrap = m_wrap;
    x.step = !s.r && !s.l && s.e;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t mk(input logic r, e, u, l, input logic [W-1:0] g);
    return {r, e, u, l, g};
  endfunction

  task automatic test_reset();
    stim_t v[$];
    exp_t  x;
    v.push_back(mk(1, 1, 1, 1, 4'b1111));
    v.push_back(mk(0, 0, 0, 0, 4'b0000));
    v.push_back(mk(0, 0, 1, 0, 4'b0000));
    foreach (v[k]) begin
      drive(v[k]);
      if (sb.size() == 0) begin errors++; $display("FAIL reset: scoreboard empty"); end
      else begin
        x = sb.pop_front();
        vectors++;
        if (bin_out !== x.bin || gray_out !== x.gray || wrap !== x.wrap) begin
          errors++;
          $display("FAIL reset[%0d]: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                   k, bin_out, gray_out, wrap, x.bin, x.gray, x.wrap);
        end
        if (v[k].r) begin
          vectors++;
          if (bin5 !== 4'd5 || gray5 !== 4'b0111 || wrap5 !== 1'b0) begin
            errors++;
            $display("FAIL reset_rstval5: got bin=%0d gray=%b wrap=%b, want bin=5 gray=0111 wrap=0",
                     bin5, gray5, wrap5);
          end
        end
        prev_gray = gray_out;
      end
    end
  endtask

  task automatic test_count_up();
    stim_t v[$];
    exp_t  x;
    v.push_back(mk(1, 0, 0, 0, 4'b0000));
    for (int i = 0; i < 17; i++) v.push_back(mk(0, 1, 1, 0, 4'b0000));
    foreach (v[k]) begin
      drive(v[k]);
      if (sb.size() == 0) begin errors++; $display("FAIL count_up: scoreboard empty"); end
      else begin
        x = sb.pop_front();
        vectors++;
        if (bin_out !== x.bin || gray_out !== x.gray || wrap !== x.wrap) begin
          errors++;
          $display("FAIL count_up[%0d]: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                   k, bin_out, gray_out, wrap, x.bin, x.gray, x.wrap);
        end
        if (x.step) begin
          vectors++;
          if ($countones(gray_out ^ prev_gray) != 1) begin
            errors++;
            $display("FAIL count_up_onebit[%0d]: gray %b -> %b, want exactly one bit change",
                     k, prev_gray, gray_out);
          end
        end
        prev_gray = gray_out;
      end
    end
  endtask

  task automatic test_count_down();
    stim_t v[$];
    exp_t  x;
    v.push_back(mk(1, 0, 0, 0, 4'b0000));
    for (int i = 0; i < 3; i++) v.push_back(mk(0, 1, 0, 0, 4'b0000));
    v.push_back(mk(0, 1, 1, 0, 4'b0000));
    v.push_back(mk(0, 1, 1, 0, 4'b0000));
    v.push_back(mk(0, 0, 0, 0, 4'b0000));
    foreach (v[k]) begin
      drive(v[k]);
      if (sb.size() == 0) begin errors++; $display("FAIL count_down: scoreboard empty"); end
      else begin
        x = sb.pop_front();
        vectors++;
        if (bin_out !== x.bin || gray_out !== x.gray || wrap !== x.wrap) begin
          errors++;
          $display("FAIL count_down[%0d]: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                   k, bin_out, gray_out, wrap, x.bin, x.gray, x.wrap);
        end
        if (x.step) begin
          vectors++;
          if ($countones(gray_out ^ prev_gray) != 1) begin
            errors++;
            $display("FAIL count_down_onebit[%0d]: gray %b -> %b, want exactly one bit change",
                     k, prev_gray, gray_out);
          end
        end
        prev_gray = gray_out;
      end
    end
  endtask

  task automatic test_load();
    stim_t v[$];
    exp_t  x;
    v.push_back(mk(0, 1, 1, 1, 4'b1101));
    v.push_back(mk(0, 1, 1, 0, 4'b0000));
    v.push_back(mk(0, 0, 0, 1, 4'b1000));
    v.push_back(mk(0, 1, 1, 0, 4'b0000));
    v.push_back(mk(0, 0, 0, 0, 4'b0000));
    v.push_back(mk(0, 0, 0, 1, 4'b0000));
    v.push_back(mk(0, 1, 0, 1, 4'b1000));
    v.push_back(mk(0, 1, 0, 1, 4'b0000));
    foreach (v[k]) begin
      drive(v[k]);
      if (sb.size() == 0) begin errors++; $display("FAIL load: scoreboard empty"); end
      else begin
        x = sb.pop_front();
        vectors++;
        if (bin_out !== x.bin || gray_out !== x.gray || wrap !== x.wrap) begin
          errors++;
          $display("FAIL load[%0d]: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                   k, bin_out, gray_out, wrap, x.bin, x.gray, x.wrap);
        end
        prev_gray = gray_out;
      end
    end
  endtask

  task automatic test_reset_priority();
    stim_t v[$];
    exp_t  x;
    v.push_back(mk(1, 0, 0, 0, 4'b0000));
    for (int i = 0; i < 7; i++) v.push_back(mk(0, 1, 1, 0, 4'b0000));
    v.push_back(mk(1, 1, 1, 1, 4'b0110));
    v.push_back(mk(0, 1, 1, 0, 4'b0000));
    foreach (v[k]) begin
      drive(v[k]);
      if (sb.size() == 0) begin errors++; $display("FAIL reset_prio: scoreboard empty"); end
      else begin
        x = sb.pop_front();
        vectors++;
        if (bin_out !== x.bin || gray_out !== x.gray || wrap !== x.wrap) begin
          errors++;
          $display("FAIL reset_prio[%0d]: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                   k, bin_out, gray_out, wrap, x.bin, x.gray, x.wrap);
        end
        if (v[k].r) begin
          vectors++;
          if (bin5 !== 4'd5 || gray5 !== 4'b0111 || wrap5 !== 1'b0) begin
            errors++;
            $display("FAIL reset_prio_rstval5[%0d]: got bin=%0d gray=%b wrap=%b, want bin=5 gray=0111 wrap=0",
                     k, bin5, gray5, wrap5);
          end
        end
        prev_gray = gray_out;
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    exp_t  x;
    s = mk(1, 0, 0, 0, 4'b0000);
    for (int k = 0; k < 10000; k++) begin
      if (k != 0) begin
        s.r = ($urandom_range(63) == 0);
        s.l = ($urandom_range(7) == 0);
        s.e = ($urandom_range(3) != 0);
        s.u = 1'($urandom_range(1));
        s.g = 4'($urandom_range(15));
      end
      drive(s);
      if (sb.size() == 0) begin errors++; $display("FAIL random: scoreboard empty"); end
      else begin
        x = sb.pop_front();
        vectors++;
        if (bin_out !== x.bin || gray_out !== x.gray || wrap !== x.wrap) begin
          errors++;
          $display("FAIL random[%0d]: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                   k, bin_out, gray_out, wrap, x.bin, x.gray, x.wrap);
        end
        if (x.step) begin
          vectors++;
          if ($countones(gray_out ^ prev_gray) != 1) begin
            errors++;
            $display("FAIL random_onebit[%0d]: gray %b -> %b, want exactly one bit change",
                     k, prev_gray, gray_out);
          end
        end
        prev_gray = gray_out;
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_reset_priority();
    test_random();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/grey_updown_counter.md
GREY_UPDOWN_COUNTER -- requirements
Module: grey_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 Parameter RST_VAL, default 0: binary count loaded on reset, must be < 2^WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  count enable; one step per cycle while high.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_gray  input  WIDTH  load value, Gray-coded.
REQ-009 bin_out  output  WIDTH  current count, binary.
REQ-010 gray_out  output  WIDTH  current count, Gray-coded.
REQ-011 wrap  output  1  one-cycle pulse marking a modular wrap.

Function
REQ-012 The internal count SHALL be a WIDTH-bit binary register driving bin_out directly.
REQ-013 gray_out SHALL equal bin_out XOR (bin_out >> 1) in every cycle, with MSB unchanged.
REQ-014 Update priority per rising edge SHALL be rst > load > en; with none asserted, count holds.
REQ-015 On load, count SHALL take the binary decode of load_gray: bit MSB = load_gray MSB; each lower bit i = load_gray[i] XOR decoded bit i+1.
REQ-016 en=1, up=1: count SHALL become count+1 modulo 2^WIDTH (2^WIDTH-1 -> 0).
REQ-017 en=1, up=0: count SHALL become count-1 modulo 2^WIDTH (0 -> 2^WIDTH-1).
REQ-018 Every enabled step SHALL change exactly one bit of gray_out, including both wrap transitions.
REQ-019 wrap SHALL be registered and high for exactly the one cycle in which the count value resulting from a wrap step (REQ-016/017 boundary) is first presented.
REQ-020 wrap SHALL NOT assert on load or reset, even when the loaded value equals 0 or 2^WIDTH-1.
REQ-021 load and en asserted together SHALL perform the load only; no step, no wrap.
REQ-022 Direction changes SHALL take effect on the same edge up is sampled; no dead cycle.
REQ-023 Latency from en/load sampled to new bin_out/gray_out SHALL be one clock.

Reset
REQ-024 rst=1 at a rising edge SHALL set bin_out=RST_VAL, gray_out=Gray(RST_VAL), wrap=0, overriding load and en.
REQ-025 Reset asserted mid-count SHALL discard the count; the first enabled step after rst deasserts SHALL proceed from RST_VAL.
REQ-026 Outputs before the first reset edge are undefined; no asynchronous behaviour is permitted.

Configuration
REQ-027 Macro GREY_CNT_REG_OUT_EN SHALL select how gray_out is produced.
REQ-028 With GREY_CNT_REG_OUT_EN defined, gray_out SHALL come from a dedicated flop loaded with Gray(next count), glitch-free and safe for clock-domain crossing, cycle-aligned with bin_out.
REQ-029 Without GREY_CNT_REG_OUT_EN, gray_out SHALL be combinational from bin_out; cycle-level values identical to REQ-028.

Verification (WIDTH=4, RST_VAL=0 unless stated)
REQ-030 rst 1 cycle, then en=1, up=1 for 17 cycles -> bin_out 0,1..15,0,1; gray_out 0000,0001,0011,0010..1000,0000; wrap high only in the cycle bin_out first shows 0 after 15.
REQ-031 From bin_out=0, en=1, up=0 -> bin_out 15 with gray_out 1000 and wrap pulse, then 14 with gray_out 1001.
REQ-032 load=1, en=1, load_gray=1101 -> bin_out 9, gray_out 1101, wrap 0; next cycle en=1, up=1 -> bin_out 10, gray_out 1111.
REQ-033 load_gray=1000 (binary 15), then en=1, up=1 -> bin_out 0, wrap pulse; load_gray=0000 alone -> no wrap.
REQ-034 Count to 7, assert rst together with load=1 and en=1 -> bin_out 0, gray_out 0000, wrap 0; RST_VAL=5 build -> bin_out 5, gray_out 0111.
REQ-035 Random en/up/load over 10000 cycles, both macro settings -> gray_out equals Gray(bin_out) every cycle, at most one gray bit changes per non-load step.
